// File: rtl/kc_pkg.sv
// Shared fetch/decode types: the queued {pc, inst} pair and the
// canonical NOP presented to decode when nothing is buffered.
package kc_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle: push side from fetch,
// pop side toward decode, plus the occupancy count.
interface fetch_buffer_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) ();

    logic                       in_valid;
    logic [XLEN-1:0]            in_inst;
    logic [XLEN-1:0]            in_pc;
    logic                       in_ready;
    logic                       out_valid;
    logic [XLEN-1:0]            out_inst;
    logic [XLEN-1:0]            out_pc;
    logic                       out_ready;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output in_valid,
        output in_inst,
        output in_pc,
        input  in_ready,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        output out_ready,
        input  count
    );

    modport slave (
        input  in_valid,
        input  in_inst,
        input  in_pc,
        output in_ready,
        output out_valid,
        output out_inst,
        output out_pc,
        input  out_ready,
        output count
    );

endinterface

// File: rtl/fetch_buffer.sv
// In-order instruction queue between fetch and decode with
// first-word fall-through head and single-cycle kill.
import kc_pkg::*;

module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           kill,
    fetch_buffer_if.slave  fb
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   wr_ptr_d;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    fetch_entry_t    head;

    // Wrap bit distinguishes full from empty when indices match
    always_comb begin
        empty = (rd_ptr_q == wr_ptr_q);
        full  = (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]) &&
                (rd_ptr_q[AW] != wr_ptr_q[AW]);
        push  = fb.in_valid && !full;
        pop   = !empty && fb.out_ready;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (kill) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !kill) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{pc: fb.in_pc, inst: fb.in_inst};
        end
    end

    always_comb begin
        head         = mem_q[rd_ptr_q[AW-1:0]];
        fb.in_ready  = !full;
        fb.out_valid = !empty;
        fb.count     = wr_ptr_q - rd_ptr_q;
        fb.out_inst  = empty ? XLEN'(NOP_INST) : XLEN'(head.inst);
        fb.out_pc    = empty ? '0 : XLEN'(head.pc);
    end

    a_no_push_full: assert property (
        @(posedge clk) disable iff (reset) !(push && full));
    a_no_pop_empty: assert property (
        @(posedge clk) disable iff (reset) !(pop && empty));

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: queue-based reference model
// compared every cycle, plus hand-computed spot checks.
module tb_fetch_buffer;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk;
    logic reset;
    logic kill;
    int   total;
    int   bad;
    ent_t mq[$];
    logic [31:0] log_pc[$];
    bit   seen_40;

    fetch_buffer_if #(.DEPTH(DEPTH), .XLEN(32)) fb ();

    fetch_buffer #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .kill  (kill),
        .fb    (fb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue updated by the handshake rules
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else begin
            automatic int  n     = mq.size();
            automatic bit  do_po = (n > 0) && fb.out_ready;
            automatic bit  do_pu = fb.in_valid && (n < DEPTH);
            if (kill) begin
                mq.delete();
            end else begin
                if (do_po) void'(mq.pop_front());
                if (do_pu) mq.push_back('{pc: fb.in_pc, inst: fb.in_inst});
            end
        end
    end

    always @(negedge clk) begin
        automatic int n = mq.size();
        chk("out_valid", 64'(fb.out_valid), 64'(n != 0));
        chk("in_ready", 64'(fb.in_ready), 64'(n < DEPTH));
        chk("count", 64'(fb.count), 64'(n));
        chk("out_inst", 64'(fb.out_inst), 64'(n != 0 ? mq[0].inst : NOP));
        chk("out_pc", 64'(fb.out_pc), 64'(n != 0 ? mq[0].pc : 32'h0));
        if (fb.out_valid && fb.out_ready && !kill && !reset) begin
            log_pc.push_back(fb.out_pc);
            if (fb.out_pc == 32'h40) seen_40 = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic rdy);
        fb.in_valid  = v;
        fb.in_pc     = pc;
        fb.in_inst   = inst;
        fb.out_ready = rdy;
    endtask

    initial begin
        total = 0;
        bad = 0;
        seen_40 = 1'b0;
        reset = 1'b1;
        kill = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("rst_count", 64'(fb.count), 64'd0);
        repeat (2) cyc();
        reset = 1'b0;
        cyc();

        // 1: idle after reset
        chk("t1_valid", 64'(fb.out_valid), 64'd0);
        chk("t1_inst", 64'(fb.out_inst), 64'h13);
        chk("t1_pc", 64'(fb.out_pc), 64'h0);
        chk("t1_ready", 64'(fb.in_ready), 64'd1);

        // 2: fill to DEPTH, fifth push refused
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 32'(32'hA0 + i), 1'b0);
            cyc();
        end
        chk("t2_count", 64'(fb.count), 64'd4);
        chk("t2_ready", 64'(fb.in_ready), 64'd0);
        chk("t2_head", 64'(fb.out_pc), 64'h0);
        chk("t2_inst", 64'(fb.out_inst), 64'hA0);
        drive(1'b1, 32'h10, 32'hA4, 1'b0);
        cyc();
        chk("t2_count5", 64'(fb.count), 64'd4);
        chk("t2_head5", 64'(fb.out_pc), 64'h0);

        // 3: pop while full does not admit the push that cycle
        drive(1'b1, 32'h10, 32'hA4, 1'b1);
        cyc();
        chk("t3_count", 64'(fb.count), 64'd3);
        chk("t3_head", 64'(fb.out_pc), 64'h4);
        drive(1'b1, 32'h10, 32'hA4, 1'b0);
        cyc();
        chk("t3_count2", 64'(fb.count), 64'd4);
        drive(1'b0, 32'h0, 32'h0, 1'b0);

        // 4: steady push+pop at count 2 across pointer wrap
        kill = 1'b1;
        cyc();
        kill = 1'b0;
        chk("t4_killed", 64'(fb.count), 64'd0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'(i * 4), 32'(32'hB0 + i), 1'b0);
            cyc();
        end
        log_pc.delete();
        for (int i = 2; i < 10; i++) begin
            drive(1'b1, 32'(i * 4), 32'(32'hB0 + i), 1'b1);
            cyc();
            chk("t4_count", 64'(fb.count), 64'd2);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        repeat (3) cyc();
        chk("t4_len", 64'(log_pc.size()), 64'd10);
        for (int i = 0; i < 10; i++) begin
            chk("t4_order", 64'(i < log_pc.size() ? log_pc[i] : 32'hFFFF),
                64'(i * 4));
        end

        // 5: kill beats simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(32'h30 + i * 4), 32'(32'hC0 + i), 1'b0);
            cyc();
        end
        chk("t5_pre", 64'(fb.count), 64'd3);
        drive(1'b1, 32'h40, 32'hC8, 1'b1);
        kill = 1'b1;
        cyc();
        kill = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        chk("t5_count", 64'(fb.count), 64'd0);
        chk("t5_valid", 64'(fb.out_valid), 64'd0);
        chk("t5_pc", 64'(fb.out_pc), 64'h0);
        repeat (2) cyc();
        chk("t5_no40", 64'(seen_40), 64'd0);

        // 6: async reset mid-cycle, then recovery
        drive(1'b1, 32'h50, 32'hD0, 1'b0);
        cyc();
        drive(1'b1, 32'h54, 32'hD1, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("t6_pre", 64'(fb.count), 64'd2);
        reset = 1'b1;
        #1;
        chk("t6_valid", 64'(fb.out_valid), 64'd0);
        chk("t6_inst", 64'(fb.out_inst), 64'h13);
        chk("t6_pc", 64'(fb.out_pc), 64'h0);
        chk("t6_count", 64'(fb.count), 64'd0);
        chk("t6_ready", 64'(fb.in_ready), 64'd1);
        cyc();
        reset = 1'b0;
        cyc();
        drive(1'b1, 32'h80, 32'hE0, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("t6_head", 64'(fb.out_pc), 64'h80);
        chk("t6_hvalid", 64'(fb.out_valid), 64'd1);
        chk("t6_hinst", 64'(fb.out_inst), 64'hE0);
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
